// File: rtl/debounce_pkg.sv
// rtl/debounce_pkg.sv - shared encodings and board defaults for the debouncer
package debounce_pkg;

  // Board defaults: 10 ms of stability at a 50 MHz clock.
  localparam int DEFAULT_SYNC_STAGES     = 2;
  localparam int DEFAULT_DEBOUNCE_CYCLES = 500000;

  typedef enum logic [1:0] {
    ST_STABLE_LO = 2'd0,
    ST_WAIT_HI   = 2'd1,
    ST_STABLE_HI = 2'd2,
    ST_WAIT_LO   = 2'd3
  } deb_state_t;

endpackage

// File: rtl/sync_ff.sv
// rtl/sync_ff.sv - generic flop-chain synchroniser for asynchronous input pins
module sync_ff
  import debounce_pkg::*;
#(
  parameter int STAGES = DEFAULT_SYNC_STAGES
) (
  input  logic clk,
  input  logic reset,
  input  logic d,
  output logic q
);

  logic [STAGES-1:0] chain;

  // Shift the raw pin through the chain; only the last flop is used downstream.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      chain <= '0;
    end else begin
      chain <= {chain[STAGES-2:0], d};
    end
  end

  assign q = chain[STAGES-1];

endmodule

// File: rtl/btn_debounce.sv
// rtl/btn_debounce.sv - pushbutton synchroniser plus stability-window debouncer
module btn_debounce
  import debounce_pkg::*;
#(
  parameter int SYNC_STAGES     = DEFAULT_SYNC_STAGES,
  parameter int DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE_CYCLES
) (
  input  logic clk,
  input  logic reset,
  input  logic btn_in,
  output logic sig_out,
  output logic stable,
  output logic glitch
);

  localparam int CNT_WIDTH = $clog2(DEBOUNCE_CYCLES);
  // Value of the counter on the edge that completes the window.
  localparam logic [CNT_WIDTH-1:0] CNT_LAST = CNT_WIDTH'(DEBOUNCE_CYCLES - 1);

  logic                 s;
  deb_state_t           state, state_n;
  logic [CNT_WIDTH-1:0] cnt, cnt_n;
  logic                 sig_n, stable_n, glitch_n;

  sync_ff #(
    .STAGES(SYNC_STAGES)
  ) u_sync (
    .clk  (clk),
    .reset(reset),
    .d    (btn_in),
    .q    (s)
  );

  // State, counter and all three outputs are registered together.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state   <= ST_STABLE_LO;
      cnt     <= '0;
      sig_out <= 1'b0;
      stable  <= 1'b1;
      glitch  <= 1'b0;
    end else begin
      state   <= state_n;
      cnt     <= cnt_n;
      sig_out <= sig_n;
      stable  <= stable_n;
      glitch  <= glitch_n;
    end
  end

  // Next-state logic; completion needs s at the new level, so an abort on the
  // completing edge wins and the counter never runs past CNT_LAST.
  always_comb begin
    state_n  = state;
    cnt_n    = cnt;
    sig_n    = sig_out;
    stable_n = stable;
    glitch_n = 1'b0;
    case (state)
      ST_STABLE_LO: begin
        if (s) begin
          state_n  = ST_WAIT_HI;
          cnt_n    = '0;
          stable_n = 1'b0;
        end
      end
      ST_WAIT_HI: begin
        if (!s) begin
          state_n  = ST_STABLE_LO;
          glitch_n = 1'b1;
          stable_n = 1'b1;
        end else if (cnt == CNT_LAST) begin
          state_n  = ST_STABLE_HI;
          sig_n    = 1'b1;
          stable_n = 1'b1;
        end else begin
          cnt_n = cnt + CNT_WIDTH'(1);
        end
      end
      ST_STABLE_HI: begin
        if (!s) begin
          state_n  = ST_WAIT_LO;
          cnt_n    = '0;
          stable_n = 1'b0;
        end
      end
      ST_WAIT_LO: begin
        if (s) begin
          state_n  = ST_STABLE_HI;
          glitch_n = 1'b1;
          stable_n = 1'b1;
        end else if (cnt == CNT_LAST) begin
          state_n  = ST_STABLE_LO;
          sig_n    = 1'b0;
          stable_n = 1'b1;
        end else begin
          cnt_n = cnt + CNT_WIDTH'(1);
        end
      end
      default: begin
        state_n = ST_STABLE_LO;
      end
    endcase
  end

endmodule
